// File: rtl/conv2d_feeder_pkg.sv
// Shared types for the conv2d_core feeder: FSM state encoding and data width.
package conv2d_feeder_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } feederState_e;

endpackage

// File: rtl/conv2d_feeder_yfifo.sv
// Show-ahead synchronous FIFO holding prefetched y partial sums.
// Popping an empty FIFO returns 0 and changes nothing.
module conv2d_feeder_yfifo
    import conv2d_feeder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        pushData_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        popData_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] store_q [DEPTH];
    logic [PW-1:0]     wrPtr_q;
    logic [PW-1:0]     rdPtr_q;
    logic [PW:0]       count_q;
    logic              doPush;
    logic              doPop;

    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign doPush    = push_i && !flush_i && (count_q != (PW+1)'(DEPTH));
    assign doPop     = pop_i && !flush_i && !empty_o;
    assign popData_o = empty_o ? '0 : store_q[rdPtr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
            if (doPush && !doPop)      count_q <= count_q + (PW+1)'(1);
            else if (doPop && !doPush) count_q <= count_q - (PW+1)'(1);
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (doPush) store_q[wrPtr_q] <= pushData_i;
    end

endmodule

// File: rtl/conv2d_feeder.sv
// Drives conv2d_core's pixel interface: streams x, prefetches y through a shared
// fixed-latency read port, and writes z results back to memory.
module conv2d_feeder
    import conv2d_feeder_pkg::*;
#(
    parameter int C_WIDTH  = 9,
    parameter int AW       = 16,
    parameter int RD_LAT   = 2,
    parameter int YF_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [AW-1:0]      cfg_base_x,
    input  logic [AW-1:0]      cfg_base_y,
    input  logic [AW-1:0]      cfg_base_z,
    input  logic [C_WIDTH-1:0] cfg_width_in,
    input  logic [C_WIDTH-1:0] cfg_height_out,
    input  logic               cfg_y_en,
    output logic               busy,
    output logic               done,
    output logic               err_ufl,
    output logic               mem_rd,
    output logic [AW-1:0]      mem_raddr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               mem_wr,
    output logic [AW-1:0]      mem_waddr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               param_ena,
    output logic [C_WIDTH-1:0] param_width_in,
    output logic [C_WIDTH-1:0] param_height_out,
    output logic               pxl_ena_x,
    output logic [DATA_W-1:0]  pxl_x,
    input  logic               pxl_ena_y,
    output logic [DATA_W-1:0]  pxl_y,
    input  logic               pxl_ena_z,
    input  logic [DATA_W-1:0]  pxl_z,
    input  logic               pxl_ovr
);

    localparam int CNT_W = 2 * C_WIDTH;
    localparam int FCW   = $clog2(YF_DEPTH) + 1;

    feederState_e       state_q, state_d;
    logic [C_WIDTH-1:0] widthIn_q, heightOut_q;
    logic [AW-1:0]      baseX_q, baseY_q, baseZ_q;
    logic               yEn_q;
    logic [CNT_W-1:0]   xIssued_q, yIssued_q;
    logic [AW-1:0]      zCnt_q;
    logic               memRd_q, rdIsY_q;
    logic [AW-1:0]      memRaddr_q;
    logic [RD_LAT-1:0]  tagValid_q, tagIsY_q;
    logic               pxlEnaX_q;
    logic [DATA_W-1:0]  pxlX_q, pxlY_q;
    logic               errUfl_q;
    logic               memWr_q;
    logic [AW-1:0]      memWaddr_q;
    logic [DATA_W-1:0]  memWdata_q;

    logic [CNT_W-1:0]   nx, ny;
    logic               startPulse, active;
    logic [7:0]         yInFlight;
    logic [15:0]        yPending;
    logic               yGo, xGo, zGo, yReq, fifoPop;
    logic               retX, retY;
    logic [DATA_W-1:0]  fifoData;
    logic [FCW-1:0]     fifoCount;
    logic               fifoEmpty;

    assign nx = CNT_W'(widthIn_q) * (CNT_W'(heightOut_q) + CNT_W'(2));
    assign ny = (CNT_W'(widthIn_q) - CNT_W'(2)) * CNT_W'(heightOut_q);

    assign startPulse = (state_q == ST_IDLE) && cfg_start && !cfg_abort;
    assign active     = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // y reads already issued but not yet in the FIFO reserve FIFO space.
    always_comb begin
        yInFlight = 8'(memRd_q && rdIsY_q);
        for (int i = 0; i < RD_LAT; i++) begin
            yInFlight = yInFlight + 8'(tagValid_q[i] && tagIsY_q[i]);
        end
    end

    assign yPending = 16'(fifoCount) + 16'(yInFlight);
    assign yGo = active && yEn_q && (yIssued_q < ny)
                 && (yPending < 16'(YF_DEPTH / 2)) && !cfg_abort;
    assign xGo = (state_q == ST_RUN) && (xIssued_q < nx) && !yGo && !cfg_abort;
    assign zGo = active && pxl_ena_z;

    assign retX    = tagValid_q[RD_LAT-1] && !tagIsY_q[RD_LAT-1];
    assign retY    = tagValid_q[RD_LAT-1] &&  tagIsY_q[RD_LAT-1];
    assign yReq    = active && pxl_ena_y;
    assign fifoPop = yReq && yEn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cfg_start) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_RUN;
                ST_RUN:   if (xIssued_q == nx) state_d = ST_DRAIN;
                ST_DRAIN: if (pxl_ovr) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        param_ena = (state_q == ST_LOAD);
        done      = (state_q == ST_DRAIN) && pxl_ovr && !cfg_abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widthIn_q   <= '0;
            heightOut_q <= '0;
            baseX_q     <= '0;
            baseY_q     <= '0;
            baseZ_q     <= '0;
            yEn_q       <= 1'b0;
            xIssued_q   <= '0;
            yIssued_q   <= '0;
            zCnt_q      <= '0;
        end else if (startPulse) begin
            widthIn_q   <= cfg_width_in;
            heightOut_q <= cfg_height_out;
            baseX_q     <= cfg_base_x;
            baseY_q     <= cfg_base_y;
            baseZ_q     <= cfg_base_z;
            yEn_q       <= cfg_y_en;
            xIssued_q   <= '0;
            yIssued_q   <= '0;
            zCnt_q      <= '0;
        end else begin
            if (xGo) xIssued_q <= xIssued_q + CNT_W'(1);
            if (yGo) yIssued_q <= yIssued_q + CNT_W'(1);
            if (zGo) zCnt_q    <= zCnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memRd_q    <= 1'b0;
            rdIsY_q    <= 1'b0;
            memRaddr_q <= '0;
        end else begin
            memRd_q <= yGo || xGo;
            if (yGo) begin
                memRaddr_q <= baseY_q + AW'(yIssued_q);
                rdIsY_q    <= 1'b1;
            end else if (xGo) begin
                memRaddr_q <= baseX_q + AW'(xIssued_q);
                rdIsY_q    <= 1'b0;
            end
        end
    end

    // Tag pipe is fed by the registered strobe so its last stage lines up with mem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tagValid_q <= '0;
            tagIsY_q   <= '0;
        end else if (cfg_abort) begin
            tagValid_q <= '0;
            tagIsY_q   <= '0;
        end else begin
            tagValid_q[0] <= memRd_q;
            tagIsY_q[0]   <= rdIsY_q;
            for (int i = 1; i < RD_LAT; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagIsY_q[i]   <= tagIsY_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pxlEnaX_q <= 1'b0;
            pxlX_q    <= '0;
            pxlY_q    <= '0;
            errUfl_q  <= 1'b0;
        end else begin
            pxlEnaX_q <= retX && !cfg_abort;
            if (retX) pxlX_q <= mem_rdata;
            if (yReq) pxlY_q <= yEn_q ? fifoData : '0;
            if (startPulse)                errUfl_q <= 1'b0;
            else if (fifoPop && fifoEmpty) errUfl_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memWr_q    <= 1'b0;
            memWaddr_q <= '0;
            memWdata_q <= '0;
        end else begin
            memWr_q <= zGo;
            if (zGo) begin
                memWaddr_q <= baseZ_q + zCnt_q;
                memWdata_q <= pxl_z;
            end
        end
    end

    conv2d_feeder_yfifo #(
        .DEPTH(YF_DEPTH)
    ) u_yfifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (cfg_abort || startPulse),
        .push_i     (retY && !cfg_abort),
        .pushData_i (mem_rdata),
        .pop_i      (fifoPop),
        .popData_o  (fifoData),
        .count_o    (fifoCount),
        .empty_o    (fifoEmpty)
    );

    assign err_ufl          = errUfl_q;
    assign mem_rd           = memRd_q;
    assign mem_raddr        = memRaddr_q;
    assign mem_wr           = memWr_q;
    assign mem_waddr        = memWaddr_q;
    assign mem_wdata        = memWdata_q;
    assign param_width_in   = widthIn_q;
    assign param_height_out = heightOut_q;
    assign pxl_ena_x        = pxlEnaX_q;
    assign pxl_x            = pxlX_q;
    assign pxl_y            = pxlY_q;

endmodule
